// File: rtl/reimu_life.sv
// reimu_life: player hit manager for the game tick domain.
//
// Tracks remaining lives and accepted hits. After a hit that leaves lives in
// hand, the player is invulnerable for INVUL_TICKS cycles and the sprite blinks.
// A hit on the last life ends the game.
//
// Ports:
//   clk22      game tick clock, rising edge
//   rst        synchronous active-high reset
//   start      level; starts or restarts a game from IDLE or OVER
//   shot       registered player-hit flag from the enemy-bullet stage
//   lives      remaining lives
//   state      0 IDLE, 1 PLAY, 2 INVUL, 3 OVER
//   invul      high while in INVUL
//   visible    player sprite enable for the renderer
//   hit_pulse  one-cycle pulse per accepted hit
//   game_over  high while in OVER
//   hits       accepted hits since the last game start, saturating at 255
//
// State table:
//   IDLE  | waiting for start; shot ignored
//   PLAY  | shot is accepted as a hit
//   INVUL | post-hit invulnerability, timer counts down, sprite blinks
//   OVER  | no lives left; waiting for start

module reimu_life #(
    parameter int LIVES       = 3,
    parameter int INVUL_TICKS = 48
) (
    input  logic       clk22,
    input  logic       rst,
    input  logic       start,
    input  logic       shot,
    output logic [2:0] lives,
    output logic [1:0] state,
    output logic       invul,
    output logic       visible,
    output logic       hit_pulse,
    output logic       game_over,
    output logic [7:0] hits
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_INVUL = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [2:0] LIVES_INIT = 3'(LIVES);
    localparam logic [7:0] TIMER_LOAD = 8'(INVUL_TICKS - 1);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [2:0] lives_d;
    logic [7:0] hits_d;
    logic [7:0] hits_inc;
    logic       visible_d;
    logic       hit_pulse_d;

    assign hits_inc = (hits == 8'hFF) ? hits : hits + 8'd1;

    always_ff @(posedge clk22) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= 8'd0;
            lives     <= LIVES_INIT;
            hits      <= 8'd0;
            visible   <= 1'b1;
            hit_pulse <= 1'b0;
            invul     <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            lives     <= lives_d;
            hits      <= hits_d;
            visible   <= visible_d;
            hit_pulse <= hit_pulse_d;
            invul     <= (state_d == ST_INVUL);
            game_over <= (state_d == ST_OVER);
        end
    end

    assign state = state_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        lives_d     = lives;
        hits_d      = hits;
        visible_d   = visible;
        hit_pulse_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PLAY;
                    lives_d = LIVES_INIT;
                    hits_d  = 8'd0;
                end
            end
            ST_PLAY: begin
                if (shot) begin
                    hit_pulse_d = 1'b1;
                    hits_d      = hits_inc;
                    if (lives > 3'd1) begin
                        lives_d = lives - 3'd1;
                        timer_d = TIMER_LOAD;
                        state_d = ST_INVUL;
                    end else begin
                        lives_d   = 3'd0;
                        visible_d = 1'b0;
                        state_d   = ST_OVER;
                    end
                end
            end
            ST_INVUL: begin
                if (timer_q == 8'd0) begin
                    state_d   = ST_PLAY;
                    visible_d = 1'b1;
                end else begin
                    // Blink follows the pre-decrement count: 4 ticks on, 4 off.
                    timer_d   = timer_q - 8'd1;
                    visible_d = timer_q[2];
                end
            end
            ST_OVER: begin
                if (start) begin
                    state_d   = ST_PLAY;
                    lives_d   = LIVES_INIT;
                    hits_d    = 8'd0;
                    visible_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
